uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_baud_gen.sv | 34 +++
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and default configuration for the UART transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_CLK_DIV    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// baud_gen: bit-period counter; restart reloads it so every state starts on a fresh period.
module baud_gen #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Wrap on the last count so consecutive bits inside one state never drift.
  always_comb begin
    cnt_nxt = cnt + CW'(1);
    if (restart || (cnt == CW'(CLK_DIV - 1))) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == CW'(CLK_DIV - 1));
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: pulls characters from an upstream FIFO and sends start/data(LSB first)/stop frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = UART_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_read_ready,
  input  logic                  fifo_read_valid,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);

  uart_tx_state_t        state;
  uart_tx_state_t        state_nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [BW-1:0]         bit_cnt;
  logic [BW-1:0]         bit_cnt_nxt;
  logic                  armed;
  logic                  tick;
  logic                  restart_c;
  logic                  tx_nxt;
  logic                  busy_nxt;
  logic                  ready_nxt;
`ifdef UART_TX_PARITY_EN
  logic                  parity;
  logic                  parity_nxt;
`endif

  baud_gen #(.CLK_DIV(CLK_DIV)) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart_c),
    .tick    (tick)
  );

  // Next state, datapath and registered-output values.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
`ifdef UART_TX_PARITY_EN
    parity_nxt  = parity;
`endif
    case (state)
      ST_IDLE: begin
        if (fifo_read_ready) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (fifo_read_valid) begin
          state_nxt = ST_START;
          shreg_nxt = fifo_data;
`ifdef UART_TX_PARITY_EN
          parity_nxt = ^fifo_data;
`endif
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick) begin
          state_nxt   = ST_DATA;
          bit_cnt_nxt = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            shreg_nxt   = shreg >> 1;
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    restart_c = (state_nxt != state);

    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_nxt = parity_nxt;
`endif
      default:   tx_nxt = 1'b1;
    endcase

    busy_nxt  = (state_nxt != ST_IDLE);
    // A request is only raised from IDLE, and never in the first cycle out of reset.
    ready_nxt = armed && (state_nxt == ST_IDLE) && !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      shreg           <= '0;
      bit_cnt         <= '0;
      armed           <= 1'b0;
      tx              <= 1'b1;
      busy            <= 1'b0;
      fifo_read_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity          <= 1'b0;
`endif
    end else begin
      state           <= state_nxt;
      shreg           <= shreg_nxt;
      bit_cnt         <= bit_cnt_nxt;
      armed           <= 1'b1;
      tx              <= tx_nxt;
      busy            <= busy_nxt;
      fifo_read_ready <= ready_nxt;
`ifdef UART_TX_PARITY_EN
      parity          <= parity_nxt;
`endif
    end
  end

`ifndef SYNTHESIS
  // Configuration and handshake sanity checks.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (CLK_DIV >= 2) else $error("uart_tx: CLK_DIV must be at least 2");
      assert (DATA_WIDTH != 0) else $error("uart_tx: DATA_WIDTH must be non-zero");
      assert (!(fifo_read_valid && (state != ST_FETCH)))
        else $error("uart_tx: fifo_read_valid outside FETCH");
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame-timeline model of the transmitter checked every cycle, plus directed literal checks.
module tb_uart_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned CD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = (DW + 3) * CD;
`else
  localparam int FL = (DW + 2) * CD;
`endif
  localparam int MAXC  = 3000;
  localparam int NEVER = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read_valid = 1'b0;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_read_ready;
  logic          tx;
  logic          busy;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fifo_empty      (fifo_empty),
    .fifo_read_ready (fifo_read_ready),
    .fifo_read_valid (fifo_read_valid),
    .fifo_data       (fifo_data),
    .tx              (tx),
    .busy            (busy)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic log_tx   [0:MAXC-1];
  logic log_busy [0:MAXC-1];
  logic log_rdy  [0:MAXC-1];

  logic [DW-1:0] q[$];
  bit            withhold = 1'b0;
  logic          rdy_seen = 1'b0;

  // Timeline model: when the next request may appear, which cycle fetches, and the frame in flight.
  int            req_ok      = NEVER;
  int            fetch_at    = -1;
  int            frame_start = -10000;
  logic [DW-1:0] frame_byte  = '0;
  logic          prev_empty;
  logic          prev_rst;

  function automatic logic frame_bit(input logic [DW-1:0] b, input int i);
    int seg;
    seg = i / int'(CD);
    if (seg == 0) return 1'b0;
    if (seg <= int'(DW)) return b[seg-1];
`ifdef UART_TX_PARITY_EN
    if (seg == int'(DW) + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // One clock: compare DUT against the model, log, then act as the upstream FIFO.
  task automatic step();
    logic e_tx, e_busy, e_rdy;
    bit   in_frame;
    prev_empty = fifo_empty;
    prev_rst   = rst_n;
    @(posedge clk);
    #1;
    cyc++;
    if (!prev_rst) begin
      frame_start = -10000;
      fetch_at    = -1;
      req_ok      = cyc + 2;
    end
    in_frame = (cyc >= frame_start) && (cyc < frame_start + FL);
    e_tx     = in_frame ? frame_bit(frame_byte, cyc - frame_start) : 1'b1;
    e_busy   = in_frame || (cyc == fetch_at);
    e_rdy    = prev_rst && (cyc >= req_ok) && !prev_empty;
    check("tx", 32'(tx), 32'(e_tx));
    check("busy", 32'(busy), 32'(e_busy));
    check("fifo_read_ready", 32'(fifo_read_ready), 32'(e_rdy));
    if (cyc < MAXC) begin
      log_tx[cyc]   = tx;
      log_busy[cyc] = busy;
      log_rdy[cyc]  = fifo_read_ready;
    end
    if (e_rdy) begin
      fetch_at = cyc + 1;
      req_ok   = NEVER;
    end
    fifo_read_valid = 1'b0;
    if (rdy_seen) begin
      if (withhold) withhold = 1'b0;
      else if (q.size() > 0) begin
        fifo_read_valid = 1'b1;
        fifo_data       = q.pop_front();
      end
    end
    if (cyc == fetch_at) begin
      if (fifo_read_valid) begin
        frame_start = cyc + 1;
        frame_byte  = fifo_data;
        req_ok      = cyc + 1 + FL;
      end else begin
        req_ok = cyc + 1;
      end
    end
    fifo_empty = (q.size() == 0);
    rdy_seen   = fifo_read_ready;
  endtask

  function automatic int count(input int which, input int from, input int to, input logic val);
    int n;
    logic v;
    n = 0;
    for (int i = from; i <= to; i++) begin
      if (i < 0 || i >= MAXC) continue;
      v = (which == 0) ? log_tx[i] : (which == 1) ? log_busy[i] : log_rdy[i];
      if (v === val) n++;
    end
    return n;
  endfunction

  function automatic int find_rdy(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      if (i >= 0 && i < MAXC && log_rdy[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  // Samples the middle of each data bit of the frame whose request pulsed at cycle p.
  function automatic logic [DW-1:0] sample_byte(input int p);
    logic [DW-1:0] b;
    int idx;
    b = '0;
    for (int k = 0; k < int'(DW); k++) begin
      idx = p + 2 + int'(CD) * (k + 1) + 1;
      if (idx < MAXC) b[k] = log_tx[idx];
    end
    return b;
  endfunction

  initial begin
    int s, p, p1, p2, i, run;

    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(fifo_read_ready), 32'd0);

    // Empty FIFO: line idle, no requests.
    s = cyc + 1;
    repeat (200) step();
    check("idle_ready_pulses", count(2, s, cyc, 1'b1), 0);
    check("idle_busy_cycles", count(1, s, cyc, 1'b1), 0);
    check("idle_tx_low", count(0, s, cyc, 1'b0), 0);

    // Single character 0xA5.
    s = cyc + 1;
    push(8'hA5);
    repeat (60) step();
    p = find_rdy(s, cyc);
    check("a5_request_seen", 32'(p >= 0), 32'd1);
    check("a5_ready_pulses", count(2, s, cyc, 1'b1), 1);
    if (p >= 0) begin
      check("a5_pre_start_high", 32'(log_tx[p+1]), 32'd1);
      check("a5_start_low", count(0, p + 2, p + 5, 1'b0), 4);
      check("a5_first_data", 32'(log_tx[p+6]), 32'd1);
      check("a5_byte", 32'(sample_byte(p)), 32'hA5);
      check("a5_stop_high", count(0, p + FL - 2, p + FL + 1, 1'b1), 4);
      check("a5_busy_cycles", count(1, s, cyc, 1'b1), FL + 1);
    end

    // Back-to-back 0x00 then 0xFF.
    s = cyc + 1;
    push(8'h00);
    push(8'hFF);
    repeat (100) step();
    p1 = find_rdy(s, cyc);
    p2 = (p1 >= 0) ? find_rdy(p1 + 1, cyc) : -1;
    check("b2b_ready_pulses", count(2, s, cyc, 1'b1), 2);
    check("b2b_second_seen", 32'(p2 >= 0), 32'd1);
    if (p2 >= 0) begin
      i = p1 + 2;
      while (i < cyc && log_tx[i] === 1'b0) i++;
      run = 0;
      while (i < cyc && log_tx[i] === 1'b1) begin
        run++;
        i++;
      end
      check("b2b_gap_high", run, 6);
      check("b2b_byte0", 32'(sample_byte(p1)), 32'h00);
      check("b2b_byte1", 32'(sample_byte(p2)), 32'hFF);
    end

    // Upstream withholds valid on the first fetch.
    s = cyc + 1;
    withhold = 1'b1;
    push(8'h5A);
    repeat (60) step();
    p1 = find_rdy(s, cyc);
    p2 = (p1 >= 0) ? find_rdy(p1 + 1, cyc) : -1;
    check("wh_retry_seen", 32'(p2 >= 0), 32'd1);
    if (p2 >= 0) begin
      check("wh_retry_spacing", p2 - p1, 2);
      check("wh_line_high", count(0, p1, p2 + 1, 1'b1), p2 - p1 + 2);
      check("wh_byte", 32'(sample_byte(p2)), 32'h5A);
    end

    // Reset in frame cycle 13 of 0x3C.
    s = cyc + 1;
    push(8'h3C);
    p = -1;
    for (int k = 0; k < 20 && p < 0; k++) begin
      step();
      p = find_rdy(s, cyc);
    end
    check("rst_request_seen", 32'(p >= 0), 32'd1);
    if (p >= 0) begin
      while (cyc < p + 14) step();
      rst_n = 1'b0;
      step();
      check("rst_tx_next", 32'(log_tx[cyc]), 32'd1);
      check("rst_busy_next", 32'(log_busy[cyc]), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      s = cyc + 1;
      repeat (30) step();
      check("rst_no_rerequest", count(2, s, cyc, 1'b1), 0);
      s = cyc + 1;
      push(8'h55);
      repeat (60) step();
      p = find_rdy(s, cyc);
      check("rst_after_pulses", count(2, s, cyc, 1'b1), 1);
      if (p >= 0) check("rst_after_byte", 32'(sample_byte(p)), 32'h55);
    end

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 gives 1, 0x03 gives 0.
    s = cyc + 1;
    push(8'h07);
    repeat (60) step();
    p = find_rdy(s, cyc);
    check("par07_seen", 32'(p >= 0), 32'd1);
    if (p >= 0) begin
      check("par07_bit", 32'(log_tx[p+2+int'(CD)*(int'(DW)+1)+1]), 32'd1);
      check("par07_busy", count(1, s, cyc, 1'b1), 45);
    end
    s = cyc + 1;
    push(8'h03);
    repeat (60) step();
    p = find_rdy(s, cyc);
    check("par03_seen", 32'(p >= 0), 32'd1);
    if (p >= 0) check("par03_bit", 32'(log_tx[p+2+int'(CD)*(int'(DW)+1)+1]), 32'd0);
`endif

    // FIFO fills while frames are in flight.
    push(8'h81);
    repeat (10) step();
    push(8'h7E);
    repeat (7) step();
    push(8'h42);
    repeat (160) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
